usb_ls_tx: RTL and testbench

Low-speed (1.5 Mbit/s) USB serial transmitter for the mouse device. Takes the packet byte stream from the HID report/packet builder over a valid/ready/last handshake and drives the D+/D- pads. It generates SYNC, LSB-first serialisation, bit stuffing, NRZI encoding and EOP. It sits directly upstream of the `usb_dp`/`usb_dn` tri-state pads in `usb_mouse_top`.

---
 rtl/usb_ls_pkg.sv | 39 +++
 rtl/usb_ls_tx_if.sv | 18 +
 rtl/usb_ls_bit_timer.sv | 28 ++
 rtl/usb_ls_tx.sv | 188 ++++++++++++++++++
 tb/tb_usb_ls_tx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_ls_pkg.sv
// usb_ls_pkg: shared types and constants for the low-speed USB transmitter.
//   line_e     - line symbol; the encoding is {dp, dn} so a line register
//                drives the pads bit-for-bit.
//   tx_state_e - transmit FSM states.
//   nrzi()     - next line symbol for one NRZI-encoded bit.
package usb_ls_pkg;

   typedef enum logic [1:0] {
      LINE_SE0 = 2'b00,
      LINE_J   = 2'b01,
      LINE_K   = 2'b10
   } line_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP_SE0,
      ST_EOP_J
   } tx_state_e;

   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam int         STUFF_LIMIT  = 6;
   localparam int         EOP_SE0_BITS = 2;
   localparam int         EOP_J_BITS   = 1;

   // A 0 toggles between J and K, a 1 holds the line.
   function automatic line_e nrzi(input line_e cur, input logic bit_val);
      line_e nxt;
      if (bit_val)
         nxt = cur;
      else if (cur == LINE_J)
         nxt = LINE_K;
      else
         nxt = LINE_J;
      return nxt;
   endfunction

endpackage

// File: rtl/usb_ls_tx_if.sv
// usb_ls_tx_if: byte-stream handshake between the packet builder and the
// low-speed transmitter.
//   tx_data  - packet byte, sent LSB first
//   tx_valid - tx_data/tx_last valid
//   tx_last  - final byte of the packet
//   tx_ready - byte taken on a cycle with tx_valid && tx_ready
// Modports: master = packet builder, slave = transmitter.
interface usb_ls_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
   modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);

endinterface

// File: rtl/usb_ls_bit_timer.sv
// usb_ls_bit_timer: modulo-CLK_DIV counter that marks the last clock of each
// bit time.
//   clk, rst_n - clock, synchronous active-low reset
//   restart    - start a fresh bit time on the next cycle
//   bit_tick   - high on the final cycle of the current bit time
module usb_ls_bit_timer #(
   parameter int CLK_DIV = 18
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic bit_tick
);

   logic [7:0] cnt_q;

   assign bit_tick = (cnt_q == 8'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (restart || bit_tick)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + 8'd1;
   end

endmodule

// File: rtl/usb_ls_tx.sv
// usb_ls_tx: low-speed (1.5 Mbit/s) USB transmitter. Takes packet bytes over
// the usb_ls_tx_if handshake and drives the D+/D- pads with SYNC, LSB-first
// data, bit stuffing, NRZI and EOP.
//   clk, rst_n     - clock, synchronous active-low reset
//   tx             - usb_ls_tx_if.slave byte stream
//   usb_dp_o/dn_o  - pad drive values (J when idle)
//   usb_oe         - pad output enable
//   tx_busy        - high from SYNC start to end of EOP
//   tx_underrun    - one-cycle pulse when the stream starves mid-packet
//   tx_pkt_count   - completed packets; live only with USB_LS_TX_STATS_EN
//                    defined, otherwise tied to zero
module usb_ls_tx #(
   parameter int CLK_DIV = 18
) (
   input  logic        clk,
   input  logic        rst_n,
   usb_ls_tx_if.slave  tx,
   output logic        usb_dp_o,
   output logic        usb_dn_o,
   output logic        usb_oe,
   output logic        tx_busy,
   output logic        tx_underrun,
   output logic [15:0] tx_pkt_count
);
   import usb_ls_pkg::*;

   tx_state_e  state_q, state_d;
   line_e      line_q, line_d;
   logic       active_q, und_q;
   logic [7:0] hold_q, sh_q;
   logic       hold_full_q, hold_last_q, last_seen_q, sh_last_q;
   logic [2:0] bit_idx_q, ones_q;
   logic [1:0] eop_cnt_q;

   logic bit_tick, accept, start, shifting, stuff_now, advance, byte_end;
   logic reload, pkt_end, underrun, eop_enter, next_bit;

   usb_ls_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .restart  (start),
      .bit_tick (bit_tick)
   );

   assign shifting = (state_q == ST_SYNC) || (state_q == ST_DATA);

   // Gated by rst_n so the builder never sees ready while reset is held.
   assign tx.tx_ready = rst_n && !hold_full_q &&
                        ((state_q == ST_IDLE) || (shifting && !last_seen_q));
   assign accept = tx.tx_valid && tx.tx_ready;
   assign start  = accept && (state_q == ST_IDLE);

   // A stuffed bit is decided before the byte boundary, so a run of six ones
   // ending a byte (or the packet) is stuffed before reload/EOP.
   assign stuff_now = shifting && bit_tick && (ones_q == 3'(STUFF_LIMIT));
   assign advance   = shifting && bit_tick && !stuff_now;
   assign byte_end  = advance && (bit_idx_q == 3'd7);
   assign pkt_end   = byte_end && sh_last_q;
   assign reload    = byte_end && !sh_last_q && hold_full_q;
   assign underrun  = byte_end && !sh_last_q && !hold_full_q;
   assign next_bit  = reload ? hold_q[0] : sh_q[1];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_SYNC;
         ST_SYNC,
         ST_DATA: begin
            if (pkt_end || underrun)
               state_d = ST_EOP_SE0;
            else if (reload)
               state_d = ST_DATA;
         end
         ST_EOP_SE0: if (bit_tick && (eop_cnt_q == 2'(EOP_SE0_BITS - 1))) state_d = ST_EOP_J;
         ST_EOP_J:   if (bit_tick && (eop_cnt_q == 2'(EOP_J_BITS - 1)))   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      eop_enter = shifting && (state_d == ST_EOP_SE0);
      line_d    = line_q;
      if (start)
         line_d = nrzi(LINE_J, SYNC_PATTERN[0]);
      else if (eop_enter)
         line_d = LINE_SE0;
      else if (stuff_now)
         line_d = nrzi(line_q, 1'b0);
      else if (advance)
         line_d = nrzi(line_q, next_bit);
      else if ((state_q == ST_EOP_SE0) && (state_d == ST_EOP_J))
         line_d = LINE_J;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Control path
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         line_q      <= LINE_J;
         active_q    <= 1'b0;
         und_q       <= 1'b0;
         hold_full_q <= 1'b0;
         hold_last_q <= 1'b0;
         last_seen_q <= 1'b0;
         sh_last_q   <= 1'b0;
         bit_idx_q   <= '0;
         ones_q      <= '0;
         eop_cnt_q   <= '0;
      end else begin
         line_q <= line_d;
         und_q  <= underrun;

         if (start)
            active_q <= 1'b1;
         else if ((state_q == ST_EOP_J) && (state_d == ST_IDLE))
            active_q <= 1'b0;

         if (accept) begin
            hold_full_q <= 1'b1;
            hold_last_q <= tx.tx_last;
            last_seen_q <= tx.tx_last || (last_seen_q && !start);
         end else if (reload) begin
            hold_full_q <= 1'b0;
         end
         // A byte offered on the underrun cycle is dropped with the packet.
         if (eop_enter)
            hold_full_q <= 1'b0;

         if (start) begin
            sh_last_q <= 1'b0;
            bit_idx_q <= '0;
            ones_q    <= {2'b00, SYNC_PATTERN[0]};
         end else if (stuff_now) begin
            ones_q <= '0;
         end else if (advance) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            ones_q    <= next_bit ? ones_q + 3'd1 : 3'd0;
            if (reload)
               sh_last_q <= hold_last_q;
         end

         if (eop_enter)
            eop_cnt_q <= '0;
         else if (bit_tick && (state_q == ST_EOP_SE0 || state_q == ST_EOP_J))
            eop_cnt_q <= (state_d != state_q) ? 2'd0 : eop_cnt_q + 2'd1;
      end
   end

   // Data path: no reset, contents only matter once loaded
   always_ff @(posedge clk) begin
      if (accept)
         hold_q <= tx.tx_data;
      if (start)
         sh_q <= SYNC_PATTERN;
      else if (reload)
         sh_q <= hold_q;
      else if (advance)
         sh_q <= sh_q >> 1;
   end

   assign usb_dp_o    = line_q[1];
   assign usb_dn_o    = line_q[0];
   assign usb_oe      = active_q;
   assign tx_busy     = active_q;
   assign tx_underrun = und_q;

`ifdef USB_LS_TX_STATS_EN
   logic [15:0] pkt_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         pkt_count_q <= '0;
      else if ((state_q == ST_EOP_J) && (state_d == ST_IDLE))
         pkt_count_q <= pkt_count_q + 16'd1;
   end

   assign tx_pkt_count = pkt_count_q;
`else
   assign tx_pkt_count = '0;
`endif

endmodule

// File: tb/tb_usb_ls_tx.sv
module tb_usb_ls_tx;

   localparam int CLK_DIV = 18;
   localparam logic [1:0] SJ = 2'b01;
   localparam logic [1:0] SK = 2'b10;
   localparam logic [1:0] S0 = 2'b00;
`ifdef USB_LS_TX_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        usb_dp_o, usb_dn_o, usb_oe, tx_busy, tx_underrun;
   logic [15:0] tx_pkt_count;

   usb_ls_tx_if ifc ();

   usb_ls_tx #(.CLK_DIV(CLK_DIV)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx           (ifc),
      .usb_dp_o     (usb_dp_o),
      .usb_dn_o     (usb_dn_o),
      .usb_oe       (usb_oe),
      .tx_busy      (tx_busy),
      .tx_underrun  (tx_underrun),
      .tx_pkt_count (tx_pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int nsym;
      int und;
   } pkt_t;

   logic [1:0] sym_q[$];
   pkt_t       pkt_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected line symbols from a text picture: J, K, 0 (= SE0).
   task automatic push_str(input string s, input int und);
      int n = 0;
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            "J": begin sym_q.push_back(SJ); n++; end
            "K": begin sym_q.push_back(SK); n++; end
            "0": begin sym_q.push_back(S0); n++; end
            default: ;
         endcase
      end
      pkt_q.push_back('{nsym: n, und: und});
   endtask

   // Reference encoder: SYNC + bytes, stuff after six ones, NRZI from J, EOP.
   task automatic push_model(input logic [7:0] b0, input logic [7:0] b1,
                             input int nbytes, input int und);
      logic [7:0] bytes [3];
      logic [1:0] ln;
      int ones, n;
      ln = SJ; ones = 0; n = 0;
      bytes[0] = 8'h80; bytes[1] = b0; bytes[2] = b1;
      for (int i = 0; i <= nbytes; i++) begin
         for (int k = 0; k < 8; k++) begin
            if (!bytes[i][k]) begin
               ln = (ln == SJ) ? SK : SJ;
               ones = 0;
            end else begin
               ones++;
            end
            sym_q.push_back(ln); n++;
            if (ones == 6) begin
               ln = (ln == SJ) ? SK : SJ;
               ones = 0;
               sym_q.push_back(ln); n++;
            end
         end
      end
      sym_q.push_back(S0); sym_q.push_back(S0); sym_q.push_back(SJ);
      pkt_q.push_back('{nsym: n + 3, und: und});
   endtask

   // Line monitor
   int         in_pkt = 0, cyc = 0, und_seen = 0, lo_cnt = 1000, last_gap = -1;
   int         abort_pkt = 0;
   logic       chg, bchg;
   logic [1:0] sym0, cur, expv;
   pkt_t       info;

   always @(negedge clk) begin
      cur = {usb_dp_o, usb_dn_o};
      if (usb_oe) begin
         if (in_pkt == 0) begin
            in_pkt = 1; cyc = 0; und_seen = 0; last_gap = lo_cnt;
         end
         if (cyc % CLK_DIV == 0) begin
            sym0 = cur; chg = 1'b0; bchg = 1'b0;
            if (sym_q.size() == 0) begin
               chk("sym_extra", 1, 0);
            end else begin
               expv = sym_q.pop_front();
               chk("symbol", {30'd0, cur}, {30'd0, expv});
            end
         end else if (cur !== sym0) begin
            chg = 1'b1;
         end
         if (tx_busy !== 1'b1) bchg = 1'b1;
         if (cyc % CLK_DIV == CLK_DIV - 1) begin
            chk("sym_hold", {31'd0, chg}, 0);
            chk("busy_mirror", {31'd0, bchg}, 0);
         end
         if (tx_underrun) begin
            und_seen++;
            chk("und_at_se0", {30'd0, cur}, {30'd0, S0});
         end
         cyc++;
      end else if (in_pkt != 0) begin
         in_pkt = 0; lo_cnt = 1;
         if (abort_pkt != 0) begin
            sym_q.delete();
            if (pkt_q.size() != 0) void'(pkt_q.pop_front());
            abort_pkt = 0;
         end else if (pkt_q.size() == 0) begin
            chk("pkt_extra", 1, 0);
         end else begin
            info = pkt_q.pop_front();
            chk("oe_len", cyc, info.nsym * CLK_DIV);
            chk("underrun_cnt", und_seen, info.und);
            chk("busy_fall", {31'd0, tx_busy}, 0);
         end
      end else begin
         lo_cnt++;
      end
   end

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic put_byte(input logic [7:0] d, input logic l);
      int t = 0;
      ifc.tx_data = d; ifc.tx_valid = 1'b1; ifc.tx_last = l;
      while (!ifc.tx_ready && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) chk("ready_timeout", 0, 1);
      @(negedge clk);
      ifc.tx_valid = 1'b0; ifc.tx_last = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while ((usb_oe || in_pkt != 0 || sym_q.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) chk("idle_timeout", 0, 1);
      chk("idle_line", {30'd0, usb_dp_o, usb_dn_o}, {30'd0, SJ});
   endtask

   initial begin
      int t;
      ifc.tx_valid = 1'b0; ifc.tx_data = 8'h00; ifc.tx_last = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_oe", {31'd0, usb_oe}, 0);
      chk("rst_dp", {31'd0, usb_dp_o}, 0);
      chk("rst_dn", {31'd0, usb_dn_o}, 1);
      chk("rst_ready", {31'd0, ifc.tx_ready}, 0);
      chk("rst_busy", {31'd0, tx_busy}, 0);
      chk("rst_underrun", {31'd0, tx_underrun}, 0);
      chk("rst_count", {16'd0, tx_pkt_count}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, ifc.tx_ready}, 1);

      // Reset in the middle of a packet
      push_model(8'hA5, 8'h00, 1, 0);
      abort_pkt = 1;
      put_byte(8'hA5, 1'b1);
      repeat (99) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_oe", {31'd0, usb_oe}, 0);
      chk("midrst_dp", {31'd0, usb_dp_o}, 0);
      chk("midrst_dn", {31'd0, usb_dn_o}, 1);
      chk("midrst_busy", {31'd0, tx_busy}, 0);
      chk("midrst_ready", {31'd0, ifc.tx_ready}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_ready_rel", {31'd0, ifc.tx_ready}, 1);
      wait_idle();
      push_model(8'h3C, 8'h00, 1, 0);
      put_byte(8'h3C, 1'b1);
      wait_idle();

      // Single byte 0xC3
      push_str("KJKJKJKK KKJKJKKK 00J", 0);
      put_byte(8'hC3, 1'b1);
      wait_idle();

      // 0xFF then 0x00: one stuffed bit
      push_str("KJKJKJKK KKKKKJJJJ KJKJKJKJ 00J", 0);
      put_byte(8'hFF, 1'b0);
      put_byte(8'h00, 1'b1);
      wait_idle();
      chk("pkt_count_3", {16'd0, tx_pkt_count}, STATS * 3);

      // Underrun: second byte never offered
      push_model(8'h5A, 8'h00, 1, 1);
      put_byte(8'h5A, 1'b0);
      wait_idle();

      // Back-to-back: second packet offered during EOP
      push_model(8'h81, 8'h00, 1, 0);
      put_byte(8'h81, 1'b1);
      t = 0;
      while (!(usb_oe && {usb_dp_o, usb_dn_o} == S0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) chk("eop_timeout", 0, 1);
      chk("ready_in_eop", {31'd0, ifc.tx_ready}, 0);
      push_model(8'h7E, 8'h00, 1, 0);
      put_byte(8'h7E, 1'b1);
      @(negedge clk);
      chk("b2b_gap", last_gap, 1);
      wait_idle();
      chk("pkt_count_final", {16'd0, tx_pkt_count}, STATS * 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
